// File: rtl/sdram_read_streamer.sv
// sdram_read_streamer: read initiator for the sdram req/ack/valid port.
// Fetches a run of consecutive 32-bit words, buffers the returns in a small FIFO and
// presents them to the draw pipeline as a valid/ready stream with a last marker.
// Outstanding reads are limited so that every return is guaranteed a FIFO slot.
module sdram_read_streamer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LEN_W = 9
) (
    input  logic             clk_draw,
    input  logic             rst_draw,
    input  logic             start,
    input  logic [22:0]      start_addr,
    input  logic [LEN_W-1:0] word_count,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [22:0]      ram_addr,
    output logic [31:0]      ram_data,
    output logic             ram_we,
    output logic             ram_req,
    input  logic             ram_ack,
    input  logic             ram_valid,
    input  logic [31:0]      ram_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [1:0]       state;
    logic             done_q;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] run_len;
    logic [LEN_W-1:0] pop_count;
    logic [CNT_W-1:0] in_flight;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      mem [DEPTH];

    logic active;
    logic credit_ok;
    logic acked;
    logic ret_ok;
    logic push;
    logic pop;
    logic last_pop;
    logic abort_hit;
    logic start_run;

    // Handshake decode; requests are only made while FIFO space covers every outstanding read.
    always_comb begin
        active    = (state == ST_ISSUE) || (state == ST_DRAIN);
        credit_ok = ({1'b0, fifo_count} + {1'b0, in_flight}) < SUM_W'(DEPTH);
        ram_req   = (state == ST_ISSUE) && (remaining != '0) && credit_ok;
        acked     = ram_req && ram_ack;
        // A return with nothing outstanding is a protocol error and is dropped.
        ret_ok    = ram_valid && (in_flight != '0);
        push      = ret_ok && active;
        out_valid = (fifo_count != '0);
        pop       = out_valid && out_ready;
        out_last  = out_valid && (pop_count == run_len - LEN_W'(1));
        last_pop  = pop && (pop_count == run_len - LEN_W'(1));
        abort_hit = abort && active;
        start_run = (state == ST_IDLE) && start && !abort && (word_count != '0);
        busy      = (state != ST_IDLE);
        done      = done_q;
        out_data  = mem[rd_ptr];
        ram_data  = '0;
        ram_we    = 1'b0;
    end

    // Run sequencing and the one-cycle done pulse.
    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (word_count == '0) done_q <= 1'b1;
                        else                  state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (abort)                                      state <= ST_FLUSH;
                    else if (acked && (remaining == LEN_W'(1)))     state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state <= ST_FLUSH;
                    end else if (last_pop) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    if (in_flight == '0) state <= ST_IDLE;
                end
            endcase
        end
    end

    // Request address and the count of requests still to be accepted.
    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            ram_addr  <= '0;
            remaining <= '0;
            run_len   <= '0;
        end else if (start_run) begin
            ram_addr  <= start_addr;
            remaining <= word_count;
            run_len   <= word_count;
        end else if (abort_hit) begin
            remaining <= '0;
        end else if (acked) begin
            ram_addr  <= ram_addr + 23'd1;
            remaining <= remaining - LEN_W'(1);
        end
    end

    // Reads accepted by the sdram whose data has not yet come back.
    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            in_flight <= '0;
        end else begin
            case ({acked, ret_ok})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Words handed to the consumer in the current run; drives out_last independently of acks.
    always_ff @(posedge clk_draw) begin
        if (rst_draw || start_run) begin
            pop_count <= '0;
        end else if (pop) begin
            pop_count <= pop_count + LEN_W'(1);
        end
    end

    // FIFO pointers and occupancy; abort empties the buffer at once.
    always_ff @(posedge clk_draw) begin
        if (rst_draw || abort_hit) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_draw) begin
        if (push) mem[wr_ptr] <= ram_q;
    end

    // A return with no read outstanding indicates a broken sdram handshake.
    valid_without_request: assert property (
        @(posedge clk_draw) disable iff (rst_draw) !(ram_valid && (in_flight == '0))
    );

endmodule

// File: tb/tb_sdram_read_streamer.sv
// Bench for sdram_read_streamer: a randomized sdram responder and a consumer drive the DUT;
// every run is checked against the expected word sequence derived from start address/count.
module tb_sdram_read_streamer;

    localparam int DEPTH = 16;
    localparam int LEN_W = 9;

    logic             clk_draw = 1'b0;
    logic             rst_draw;
    logic             start;
    logic [22:0]      start_addr;
    logic [LEN_W-1:0] word_count;
    logic             abort;
    logic             busy;
    logic             done;
    logic [22:0]      ram_addr;
    logic [31:0]      ram_data;
    logic             ram_we;
    logic             ram_req;
    logic             ram_ack;
    logic             ram_valid;
    logic [31:0]      ram_q;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_last;

    sdram_read_streamer #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk_draw   (clk_draw),
        .rst_draw   (rst_draw),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .ram_req    (ram_req),
        .ram_ack    (ram_ack),
        .ram_valid  (ram_valid),
        .ram_q      (ram_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 clk_draw = ~clk_draw;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // sdram model controls and logs
    int          lat_min  = 3;
    int          lat_max  = 3;
    int          ack_pct  = 100;
    bit          sd_flush = 0;
    int          last_due = 0;
    logic [22:0] ack_log[$];
    logic [31:0] ret_q[$];
    int          due_q[$];

    // consumer / monitor
    int          ready_mode = 0;
    logic [31:0] pop_data[$];
    bit          pop_last[$];
    int          done_cnt = 0;

    // Contents of the simulated sdram at a given word address.
    function automatic logic [31:0] mem_word(input logic [22:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    always @(posedge clk_draw) cyc <= cyc + 1;

    // sdram responder: random acceptance, in-order returns after a latency.
    initial begin
        ram_ack = 0; ram_valid = 0; ram_q = '0;
        forever begin
            @(posedge clk_draw); #2;
            if (sd_flush) begin
                ret_q.delete(); due_q.delete();
                ram_ack = 0; ram_valid = 0; sd_flush = 0;
            end else begin
                ram_valid = 0;
                if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    ram_valid = 1;
                    ram_q = ret_q.pop_front();
                    void'(due_q.pop_front());
                end
                ram_ack = 0;
                if (ram_req && ($urandom_range(99) < ack_pct)) begin
                    int d;
                    ram_ack = 1;
                    ack_log.push_back(ram_addr);
                    d = cyc + int'($urandom_range(lat_max, lat_min));
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    due_q.push_back(d);
                    ret_q.push_back(mem_word(ram_addr));
                end
            end
        end
    end

    // Consumer ready generation.
    initial begin
        out_ready = 0;
        forever begin
            @(posedge clk_draw); #3;
            case (ready_mode)
                0:       out_ready = 0;
                1:       out_ready = 1;
                default: out_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // Record accepted stream words and done pulses.
    initial begin
        forever begin
            @(negedge clk_draw);
            if (!rst_draw) begin
                if (done) done_cnt++;
                if (out_valid && out_ready) begin
                    pop_data.push_back(out_data);
                    pop_last.push_back(out_last);
                end
            end
        end
    end

    task automatic clear_logs();
        ack_log.delete(); pop_data.delete(); pop_last.delete(); done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [22:0] a, input int n);
        @(posedge clk_draw); #1;
        start_addr = a; word_count = LEN_W'(n); start = 1;
        @(posedge clk_draw); #1;
        start = 0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit timed_out, output bit done_seen);
        timed_out = 1; done_seen = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk_draw); #1;
            if (!busy) begin
                timed_out = 0; done_seen = done;
                break;
            end
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge clk_draw);
        #1;
    endtask

    task automatic test_reset();
        rst_draw = 1;
        repeat (3) @(posedge clk_draw);
        #1;
        n_checks++;
        if ({busy, done, ram_req, out_valid, out_last, ram_we} !== 6'b0 || ram_addr !== 23'd0
            || ram_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b req=%b ov=%b last=%b we=%b addr=%h data=%h, want all 0",
                     busy, done, ram_req, out_valid, out_last, ram_we, ram_addr, ram_data);
        end
        rst_draw = 0;
        repeat (2) @(posedge clk_draw);
        #1;
        n_checks++;
        if (busy !== 1'b0 || ram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b req=%b, want 0 0", busy, ram_req);
        end
    endtask

    task automatic test_basic();
        bit to, ds;
        logic [22:0] a = 23'h000100;
        int n = 4;
        clear_logs();
        lat_min = 3; lat_max = 3; ack_pct = 100; ready_mode = 1;
        pulse_start(a, n);
        n_checks++;
        if (ram_req !== 1'b1 || ram_addr !== a) begin
            n_fail++;
            $display("FAIL basic_req_rise: got req=%b addr=%h, want 1 %h", ram_req, ram_addr, a);
        end
        wait_idle(200, to, ds);
        n_checks++;
        if (to || !ds) begin
            n_fail++;
            $display("FAIL basic_finish: got timeout=%b done_at_idle=%b, want 0 1", to, ds);
        end
        settle();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (i >= ack_log.size() || ack_log[i] !== a + 23'(i)) begin
                n_fail++;
                $display("FAIL basic_addr[%0d]: got %h, want %h", i, ack_log[i], a + 23'(i));
            end
            n_checks++;
            if (i >= pop_data.size() || pop_data[i] !== mem_word(a + 23'(i))
                || pop_last[i] !== (i == n - 1)) begin
                n_fail++;
                $display("FAIL basic_word[%0d]: got %h last=%b, want %h last=%b", i, pop_data[i],
                         pop_last[i], mem_word(a + 23'(i)), (i == n - 1));
            end
        end
        n_checks++;
        if (pop_data.size() != n || ack_log.size() != n || done_cnt != 1 || ram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_counts: got words=%0d acks=%0d done=%0d req=%b, want %0d %0d 1 0",
                     pop_data.size(), ack_log.size(), done_cnt, ram_req, n, n);
        end
    endtask

    task automatic test_backpressure();
        bit to, ds;
        logic [22:0] a = 23'($urandom);
        int n = 40;
        clear_logs();
        lat_min = 1; lat_max = 4; ack_pct = 100; ready_mode = 0;
        pulse_start(a, n);
        repeat (60) @(posedge clk_draw);
        #1;
        n_checks++;
        if (ack_log.size() != DEPTH || ram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_credit: got acks=%0d req=%b, want %0d 0", ack_log.size(), ram_req, DEPTH);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== mem_word(a) || pop_data.size() != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got ov=%b data=%h pops=%0d, want 1 %h 0", out_valid, out_data,
                     pop_data.size(), mem_word(a));
        end
        repeat (3) @(posedge clk_draw);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== mem_word(a)) begin
            n_fail++;
            $display("FAIL bp_stable: got ov=%b data=%h, want 1 %h", out_valid, out_data, mem_word(a));
        end
        ready_mode = 2;
        wait_idle(1000, to, ds);
        settle();
        n_checks++;
        if (to || pop_data.size() != n || done_cnt != 1) begin
            n_fail++;
            $display("FAIL bp_finish: got timeout=%b words=%0d done=%0d, want 0 %0d 1", to,
                     pop_data.size(), done_cnt, n);
        end
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (i >= pop_data.size() || pop_data[i] !== mem_word(a + 23'(i))
                || pop_last[i] !== (i == n - 1)) begin
                n_fail++;
                $display("FAIL bp_word[%0d]: got %h last=%b, want %h last=%b", i, pop_data[i],
                         pop_last[i], mem_word(a + 23'(i)), (i == n - 1));
            end
        end
    endtask

    task automatic test_wrap();
        bit to, ds;
        logic [22:0] a = 23'h7FFFFE;
        logic [22:0] exp_addr[4];
        exp_addr[0] = 23'h7FFFFE; exp_addr[1] = 23'h7FFFFF;
        exp_addr[2] = 23'h000000; exp_addr[3] = 23'h000001;
        clear_logs();
        lat_min = 1; lat_max = 3; ack_pct = 70; ready_mode = 1;
        pulse_start(a, 4);
        wait_idle(200, to, ds);
        settle();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= ack_log.size() || ack_log[i] !== exp_addr[i]
                || i >= pop_data.size() || pop_data[i] !== mem_word(exp_addr[i])) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got addr=%h data=%h, want %h %h", i, ack_log[i],
                         pop_data[i], exp_addr[i], mem_word(exp_addr[i]));
            end
        end
        n_checks++;
        if (to || done_cnt != 1) begin
            n_fail++;
            $display("FAIL wrap_finish: got timeout=%b done=%0d, want 0 1", to, done_cnt);
        end
    endtask

    task automatic test_abort();
        bit to, ds;
        int pops_at_abort;
        logic [22:0] a = 23'($urandom);
        clear_logs();
        lat_min = 2; lat_max = 2; ack_pct = 100; ready_mode = 1;
        pulse_start(a, 8);
        for (int i = 0; i < 50 && ack_log.size() < 3; i++) begin
            @(posedge clk_draw); #1;
        end
        ack_pct = 0;
        abort = 1;
        @(posedge clk_draw); #1;
        abort = 0;
        pops_at_abort = pop_data.size();
        n_checks++;
        if (ram_req !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_flush: got req=%b ov=%b busy=%b, want 0 0 1", ram_req, out_valid, busy);
        end
        wait_idle(100, to, ds);
        n_checks++;
        if (to || due_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_drain: got timeout=%b pending=%0d, want 0 0", to, due_q.size());
        end
        settle();
        n_checks++;
        if (ack_log.size() != 3 || done_cnt != 0 || pop_data.size() != pops_at_abort
            || pop_data.size() > 3) begin
            n_fail++;
            $display("FAIL abort_result: got acks=%0d done=%0d pops=%0d (at abort %0d), want 3 0 <=3 unchanged",
                     ack_log.size(), done_cnt, pop_data.size(), pops_at_abort);
        end
        for (int i = 0; i < pop_data.size(); i++) begin
            n_checks++;
            if (pop_data[i] !== mem_word(a + 23'(i)) || pop_last[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_word[%0d]: got %h last=%b, want %h last=0", i, pop_data[i],
                         pop_last[i], mem_word(a + 23'(i)));
            end
        end
        ack_pct = 100;
    endtask

    task automatic test_zero_and_busy_start();
        bit to, ds;
        logic [22:0] a = 23'($urandom);
        clear_logs();
        lat_min = 1; lat_max = 3; ack_pct = 100; ready_mode = 1;
        pulse_start(23'h1234, 0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: got done=%b busy=%b req=%b, want 1 0 0", done, busy, ram_req);
        end
        @(posedge clk_draw); #1;
        n_checks++;
        if (done !== 1'b0 || ack_log.size() != 0) begin
            n_fail++;
            $display("FAIL zero_pulse: got done=%b acks=%0d, want 0 0", done, ack_log.size());
        end
        clear_logs();
        pulse_start(a, 6);
        pulse_start(a + 23'h400, 3);
        wait_idle(300, to, ds);
        settle();
        n_checks++;
        if (to || ack_log.size() != 6 || pop_data.size() != 6 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL busy_start: got timeout=%b acks=%0d words=%0d done=%0d, want 0 6 6 1",
                     to, ack_log.size(), pop_data.size(), done_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= pop_data.size() || ack_log[i] !== a + 23'(i)
                || pop_data[i] !== mem_word(a + 23'(i)) || pop_last[i] !== (i == 5)) begin
                n_fail++;
                $display("FAIL busy_start_word[%0d]: got addr=%h data=%h, want %h %h", i, ack_log[i],
                         pop_data[i], a + 23'(i), mem_word(a + 23'(i)));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit to, ds;
        logic [22:0] a = 23'($urandom);
        clear_logs();
        lat_min = 1; lat_max = 3; ack_pct = 100; ready_mode = 0;
        pulse_start(a, 6);
        for (int i = 0; i < 50 && ack_log.size() < 6; i++) begin
            @(posedge clk_draw); #1;
        end
        repeat (5) @(posedge clk_draw);
        #1;
        n_checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got busy=%b ov=%b, want 1 1", busy, out_valid);
        end
        rst_draw = 1; sd_flush = 1;
        @(posedge clk_draw); #1;
        rst_draw = 0;
        n_checks++;
        if ({busy, done, ram_req, out_valid, out_last} !== 5'b0 || ram_addr !== 23'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got busy=%b done=%b req=%b ov=%b last=%b addr=%h, want all 0",
                     busy, done, ram_req, out_valid, out_last, ram_addr);
        end
        clear_logs();
        a = 23'($urandom);
        ready_mode = 1;
        pulse_start(a, 2);
        wait_idle(100, to, ds);
        settle();
        n_checks++;
        if (to || pop_data.size() != 2 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL rst_rerun: got timeout=%b words=%0d done=%0d, want 0 2 1", to,
                     pop_data.size(), done_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= pop_data.size() || pop_data[i] !== mem_word(a + 23'(i))
                || pop_last[i] !== (i == 1)) begin
                n_fail++;
                $display("FAIL rst_rerun_word[%0d]: got %h, want %h", i, pop_data[i],
                         mem_word(a + 23'(i)));
            end
        end
    endtask

    task automatic test_random_runs();
        bit to, ds;
        for (int r = 0; r < 6; r++) begin
            logic [22:0] a = 23'($urandom);
            int n = int'($urandom_range(50, 1));
            int errs = 0;
            clear_logs();
            lat_min = 1; lat_max = 5; ack_pct = 60; ready_mode = 2;
            pulse_start(a, n);
            wait_idle(3000, to, ds);
            settle();
            n_checks++;
            if (to || !ds || done_cnt != 1 || pop_data.size() != n || ack_log.size() != n) begin
                n_fail++;
                $display("FAIL rand%0d_finish: got timeout=%b done_at_idle=%b done=%0d words=%0d acks=%0d, want 0 1 1 %0d %0d",
                         r, to, ds, done_cnt, pop_data.size(), ack_log.size(), n, n);
            end
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (i >= pop_data.size() || ack_log[i] !== a + 23'(i)
                    || pop_data[i] !== mem_word(a + 23'(i)) || pop_last[i] !== (i == n - 1)) begin
                    n_fail++;
                    if (errs++ < 4)
                        $display("FAIL rand%0d_word[%0d]: got addr=%h data=%h last=%b, want %h %h %b",
                                 r, i, ack_log[i], pop_data[i], pop_last[i], a + 23'(i),
                                 mem_word(a + 23'(i)), (i == n - 1));
                end
            end
        end
    endtask

    initial begin
        rst_draw = 1; start = 0; abort = 0; start_addr = '0; word_count = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_abort();
        test_zero_and_busy_start();
        test_reset_mid_run();
        test_random_runs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
